// File: rtl/stopwatch_button_ctrl.sv
// rtl/stopwatch_button_ctrl.sv - Front-panel button front end: sync, debounce, start/stop/reset command pulses
// Two raw buttons in, single-cycle stopwatch commands out, guarded by the stopwatch status bus.

module stopwatch_button_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only survives while the synchronized input disagrees with the
  // debounced level; one agreeing cycle restarts the qualification window.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;
endmodule

module stopwatch_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LONG_PRESS_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       btn_ss_db,
  output logic       btn_rst_db
);
  localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_HELD = 2'b01,
    R_DONE = 2'b10
  } rst_state_e;

  logic          db_ss, db_rst;
  logic          db_ss_dly_q, db_ss_dly_d;
  logic          db_rst_dly_q, db_rst_dly_d;
  logic          rise_ss, rise_rst;
  rst_state_e    state_q, state_d;
  logic [LW-1:0] lp_cnt_q, lp_cnt_d;
  logic [LW-1:0] lp_inc;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          reset_q, reset_d;

  stopwatch_button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk (clk),
    .rst (rst),
    .raw (btn_ss_raw),
    .db  (db_ss)
  );

  stopwatch_button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk (clk),
    .rst (rst),
    .raw (btn_rst_raw),
    .db  (db_rst)
  );

  assign db_ss_dly_d  = db_ss;
  assign db_rst_dly_d = db_rst;
  assign rise_ss      = db_ss & ~db_ss_dly_q;
  assign rise_rst     = db_rst & ~db_rst_dly_q;
  assign lp_inc       = lp_cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    lp_cnt_d = lp_cnt_q;
    reset_d  = 1'b0;
    start_d  = 1'b0;
    stop_d   = 1'b0;

    case (state_q)
      R_IDLE: begin
        if (rise_rst) begin
          if (status != ST_RUNNING) begin
            reset_d = 1'b1;
            state_d = R_DONE;
          end else begin
            lp_cnt_d = '0;
            state_d  = R_HELD;
          end
        end
      end
      // The running guard is decided once on the press; only hold time matters here.
      R_HELD: begin
        if (!db_rst) begin
          lp_cnt_d = '0;
          state_d  = R_IDLE;
        end else if (lp_inc == LP_LAST) begin
          lp_cnt_d = '0;
          reset_d  = 1'b1;
          state_d  = R_DONE;
        end else begin
          lp_cnt_d = lp_inc;
        end
      end
      R_DONE: begin
        if (!db_rst) begin
          state_d = R_IDLE;
        end
      end
      default: begin
        lp_cnt_d = '0;
        state_d  = R_IDLE;
      end
    endcase

    // A reset in the same cycle swallows the toggle press outright.
    if (rise_ss && !reset_d) begin
      case (status)
        ST_IDLE, ST_PAUSED: start_d = 1'b1;
        ST_RUNNING:         stop_d  = 1'b1;
        default:            ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_ss_dly_q  <= 1'b0;
      db_rst_dly_q <= 1'b0;
      state_q      <= R_IDLE;
      lp_cnt_q     <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      reset_q      <= 1'b0;
    end else begin
      db_ss_dly_q  <= db_ss_dly_d;
      db_rst_dly_q <= db_rst_dly_d;
      state_q      <= state_d;
      lp_cnt_q     <= lp_cnt_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      reset_q      <= reset_d;
    end
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign reset      = reset_q;
  assign btn_ss_db  = db_ss;
  assign btn_rst_db = db_rst;
endmodule
